// File: rtl/ac_pkg.sv
// Shared types and constants for the AccessControl terminal arbiter.
// State encoding, request codes and bus widths.
package ac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SESSION = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] REQ_NONE   = 2'b00;
  localparam logic [1:0] REQ_ACCESS = 2'b01;

  localparam int DATA_W   = 16;
  localparam int STATUS_W = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Searches upward from ptr+1, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int          pos;
  logic [IW-1:0] sel;

  // Walk from the farthest candidate down so the nearest one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    sel   = '0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(ptr) + k) % N;
      sel = IW'(pos);
      if (req[sel]) begin
        valid = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/access_arbiter.sv
// Round-robin session arbiter sharing one AccessControl
// between N terminals, with idle-timeout reclaim.
module access_arbiter
  import ac_pkg::*;
#(
  parameter int N_TERM  = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_TERM-1:0]            term_req,
  input  logic [2*N_TERM-1:0]          term_request,
  input  logic [DATA_W*N_TERM-1:0]     term_data,
  input  logic [N_TERM-1:0]            term_load,
  output logic [N_TERM-1:0]            term_grant,
  output logic [STATUS_W*N_TERM-1:0]   term_status,
  output logic [N_TERM-1:0]            term_timeout,
  output logic [1:0]                   ac_request,
  output logic [DATA_W-1:0]            ac_data,
  output logic                         ac_data_load,
  input  logic [STATUS_W-1:0]          ac_status
);

  localparam int IW = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 ptr_q, ptr_d;
  logic [IW-1:0]                 own_q, own_d;
  logic [N_TERM-1:0]             grant_q, grant_d;
  logic [STATUS_W*N_TERM-1:0]    status_q, status_d;
  logic [N_TERM-1:0]             tmo_q, tmo_d;
  logic [1:0]                    areq_q, areq_d;
  logic [DATA_W-1:0]             adata_q, adata_d;
  logic                          aload_q, aload_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic                          pick_vld;
  logic [IW-1:0]                 pick_idx;

  logic [1:0]                    own_req;
  logic [DATA_W-1:0]             own_data;
  logic                          own_load;
  logic                          own_hold;

  rr_picker #(
    .N  (N_TERM),
    .IW (IW)
  ) u_pick (
    .req   (term_req),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign own_req  = term_request[2*own_q +: 2];
  assign own_data = term_data[DATA_W*own_q +: DATA_W];
  assign own_load = term_load[own_q];
  assign own_hold = term_req[own_q];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    grant_d  = grant_q;
    status_d = '0;
    tmo_d    = '0;
    areq_d   = areq_q;
    adata_d  = adata_q;
    aload_d  = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          own_d   = pick_idx;
          ptr_d   = pick_idx;
          grant_d = {{(N_TERM-1){1'b0}}, 1'b1} << pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        areq_d = own_req;
        cnt_d  = '0;
        status_d[STATUS_W*own_q +: STATUS_W] = ac_status;
        state_d = SESSION;
      end
      SESSION: begin
        areq_d  = own_req;
        adata_d = own_data;
        aload_d = own_load;
        status_d[STATUS_W*own_q +: STATUS_W] = ac_status;
        cnt_d   = own_load ? '0 : cnt_q + 1'b1;
        // A dropped request wins over a simultaneous timeout.
        if (!own_hold) begin
          state_d = RELEASE;
        end else if (!own_load &&
                     cnt_q == CNT_W'(TIMEOUT-1)) begin
          tmo_d[own_q] = 1'b1;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        areq_d  = REQ_NONE;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(N_TERM-1);
      own_q    <= '0;
      grant_q  <= '0;
      status_q <= '0;
      tmo_q    <= '0;
      areq_q   <= REQ_NONE;
      adata_q  <= '0;
      aload_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      grant_q  <= grant_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      areq_q   <= areq_d;
      adata_q  <= adata_d;
      aload_q  <= aload_d;
      cnt_q    <= cnt_d;
    end
  end

  assign term_grant   = grant_q;
  assign term_status  = status_q;
  assign term_timeout = tmo_q;
  assign ac_request   = areq_q;
  assign ac_data      = adata_q;
  assign ac_data_load = aload_q;

endmodule

// File: tb/tb_access_arbiter.sv
// Self-checking bench for access_arbiter (N_TERM=4, TIMEOUT=8).
// Forwarded loads are checked against a scoreboard queue.
module tb_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  term_req;
  logic [7:0]  term_request;
  logic [63:0] term_data;
  logic [3:0]  term_load;
  logic [3:0]  term_grant;
  logic [11:0] term_status;
  logic [3:0]  term_timeout;
  logic [1:0]  ac_request;
  logic [15:0] ac_data;
  logic        ac_data_load;
  logic [2:0]  ac_status;

  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  always #5 clk = ~clk;

  access_arbiter #(
    .N_TERM  (4),
    .TIMEOUT (8),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .term_req     (term_req),
    .term_request (term_request),
    .term_data    (term_data),
    .term_load    (term_load),
    .term_grant   (term_grant),
    .term_status  (term_status),
    .term_timeout (term_timeout),
    .ac_request   (ac_request),
    .ac_data      (ac_data),
    .ac_data_load (ac_data_load),
    .ac_status    (ac_status)
  );

  // Every forwarded load must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (ac_data_load === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL fwd_unexpected got req=%b data=%h want none",
                 ac_request, ac_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ac_request, ac_data} !== mon_e) begin
          fails++;
          $display("FAIL fwd_data got %h want %h",
                   {ac_request, ac_data}, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic idle_out();
    term_req  = '0;
    term_load = '0;
    repeat (4) step();
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (term_grant == 4'b0 && n < 12) begin
      step();
      n++;
    end
    tests++;
    if (term_grant == 4'b0) begin
      fails++;
      $display("FAIL wait_grant got %b want nonzero", term_grant);
    end
  endtask

  task automatic test_reset();
    term_req = 4'hF;
    rst = 1'b1;
    step();
    step();
    tests++;
    if ({term_grant, term_status, term_timeout} !== 20'h0) begin
      fails++;
      $display("FAIL reset_term got %h want 0",
               {term_grant, term_status, term_timeout});
    end
    tests++;
    if ({ac_request, ac_data, ac_data_load} !== 19'h0) begin
      fails++;
      $display("FAIL reset_ac got %h want 0",
               {ac_request, ac_data, ac_data_load});
    end
    rst = 1'b0;
    step();
    tests++;
    if (term_grant !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_grant got %b want 0001", term_grant);
    end
    idle_out();
    tests++;
    if (term_grant !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle got %b want 0000", term_grant);
    end
  endtask

  task automatic test_forward();
    term_req = 4'b0001;
    term_data[15:0] = 16'h1476;
    wait_grant();
    tests++;
    if (term_grant !== 4'b0001) begin
      fails++;
      $display("FAIL fwd_grant got %b want 0001", term_grant);
    end
    step();
    tests++;
    if (ac_request !== 2'b01 || ac_data_load !== 1'b0) begin
      fails++;
      $display("FAIL fwd_grant_cycle got req=%b load=%b want 01/0",
               ac_request, ac_data_load);
    end
    term_load[0] = 1'b1;
    exp_q.push_back({2'b01, 16'h1476});
    step();
    tests++;
    if (ac_data_load !== 1'b1 || ac_data !== 16'h1476 ||
        ac_request !== 2'b01) begin
      fails++;
      $display("FAIL fwd_out got load=%b data=%h req=%b want 1/1476/01",
               ac_data_load, ac_data, ac_request);
    end
    term_load = '0;
    ac_status = 3'b101;
    step();
    tests++;
    if (ac_data_load !== 1'b0) begin
      fails++;
      $display("FAIL fwd_pulse got %b want 0", ac_data_load);
    end
    tests++;
    if (term_status !== 12'h005) begin
      fails++;
      $display("FAIL fwd_status got %h want 005", term_status);
    end
  endtask

  task automatic test_isolation();
    term_data[47:32] = 16'hAAAA;
    term_load[2] = 1'b1;
    step();
    term_load = '0;
    tests++;
    if (ac_data_load !== 1'b0 || ac_data !== 16'h1476) begin
      fails++;
      $display("FAIL iso got load=%b data=%h want 0/1476",
               ac_data_load, ac_data);
    end
    idle_out();
    ac_status = 3'b000;
    tests++;
    if (term_grant !== 4'b0 || term_status !== 12'h0) begin
      fails++;
      $display("FAIL iso_release got grant=%b status=%h want 0/0",
               term_grant, term_status);
    end
  endtask

  task automatic test_round_robin();
    int ord[4];
    int o;
    ord = '{0, 1, 3, 0};
    term_req = 4'b1011;
    do_reset();
    wait_grant();
    for (int k = 0; k < 4; k++) begin
      o = ord[k];
      tests++;
      if (term_grant !== 4'(1 << o)) begin
        fails++;
        $display("FAIL rr_order[%0d] got %b want %b",
                 k, term_grant, 4'(1 << o));
      end
      step();
      tests++;
      if (ac_request !== 2'b01) begin
        fails++;
        $display("FAIL rr_grant_req[%0d] got %b want 01",
                 k, ac_request);
      end
      term_data[16*o +: 16] = 16'hC000 + 16'(k);
      term_load[o] = 1'b1;
      exp_q.push_back({2'b01, 16'hC000 + 16'(k)});
      step();
      term_load[o] = 1'b0;
      term_req[o] = 1'b0;
      step();
      tests++;
      if (term_grant !== 4'(1 << o)) begin
        fails++;
        $display("FAIL rr_release_hold[%0d] got %b want %b",
                 k, term_grant, 4'(1 << o));
      end
      step();
      tests++;
      if (term_grant !== 4'b0 || ac_request !== 2'b00) begin
        fails++;
        $display("FAIL rr_gap[%0d] got grant=%b req=%b want 0/00",
                 k, term_grant, ac_request);
      end
      term_req[o] = 1'b1;
      step();
    end
    idle_out();
  endtask

  task automatic test_timeout();
    term_req = 4'b0010;
    do_reset();
    wait_grant();
    tests++;
    if (term_grant !== 4'b0010) begin
      fails++;
      $display("FAIL tmo_grant got %b want 0010", term_grant);
    end
    term_req = 4'b1010;
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      tests++;
      if (term_timeout !== 4'b0) begin
        fails++;
        $display("FAIL tmo_early[%0d] got %b want 0000",
                 i, term_timeout);
      end
    end
    step();
    tests++;
    if (term_timeout !== 4'b0010) begin
      fails++;
      $display("FAIL tmo_pulse got %b want 0010", term_timeout);
    end
    step();
    tests++;
    if (term_timeout !== 4'b0 || term_grant !== 4'b0) begin
      fails++;
      $display("FAIL tmo_after got tmo=%b grant=%b want 0/0",
               term_timeout, term_grant);
    end
    step();
    tests++;
    if (term_grant !== 4'b1000) begin
      fails++;
      $display("FAIL tmo_next got %b want 1000", term_grant);
    end
  endtask

  task automatic test_reset_mid();
    step();
    term_data[63:48] = 16'h5A5A;
    term_load[3] = 1'b1;
    exp_q.push_back({2'b01, 16'h5A5A});
    step();
    tests++;
    if (ac_data_load !== 1'b1) begin
      fails++;
      $display("FAIL mid_load got %b want 1", ac_data_load);
    end
    rst = 1'b1;
    step();
    tests++;
    if (ac_data_load !== 1'b0 || term_grant !== 4'b0 ||
        ac_data !== 16'h0 || ac_request !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset got load=%b grant=%b data=%h req=%b",
               ac_data_load, term_grant, ac_data, ac_request);
    end
    rst = 1'b0;
    term_load = '0;
    term_req = '0;
    step();
    tests++;
    if (term_grant !== 4'b0) begin
      fails++;
      $display("FAIL mid_idle got %b want 0000", term_grant);
    end
    term_req = 4'b0001;
    step();
    tests++;
    if (term_grant !== 4'b0001) begin
      fails++;
      $display("FAIL mid_regrant got %b want 0001", term_grant);
    end
    idle_out();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL fwd_missing got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst          = 1'b1;
    term_req     = '0;
    term_request = 8'h55;
    term_data    = '0;
    term_load    = '0;
    ac_status    = '0;
    test_reset();
    test_forward();
    test_isolation();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/access_arbiter.md
Name: access_arbiter

Overview:
- Shares one AccessControl instance between N user terminals (keypads/consoles). The access_arbiter is the only driver of the AccessControl inputs.
- Grants are round-robin. Exactly one terminal owns a session at a time.
- For the owner, the block forwards the request code, the 16-bit data word and the load strobe to AccessControl, and routes the 3-bit status frame back.
- Abandoned sessions are reclaimed by an idle timeout.

Parameters:
- N_TERM, 4, number of terminals (2..8)
- TIMEOUT, 64, idle cycles in SESSION without a term_load before forced release (>=2)
- CNT_W, 8, width of the idle counter (2^CNT_W > TIMEOUT)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- term_req  in  N_TERM  terminal i requests / holds a session
- term_request  in  2*N_TERM  per-terminal request code, slice [2i+1:2i]
- term_data  in  16*N_TERM  per-terminal data word, slice [16i+15:16i]
- term_load  in  N_TERM  per-terminal data-load strobe
- term_grant  out  N_TERM  one-hot; terminal i owns the session
- term_status  out  3*N_TERM  status frame for the owner; all other slices are 0
- term_timeout  out  N_TERM  one-cycle pulse to a terminal whose session timed out
- ac_request  out  2  to AccessControl _Request
- ac_data  out  16  to AccessControl _Data_In
- ac_data_load  out  1  to AccessControl _Data_In_Load
- ac_status  in  3  from AccessControl _Status_Frame

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a rising edge): state=IDLE, rr_ptr=N_TERM-1, term_grant=0, term_status=0, term_timeout=0, ac_request=2'b00, ac_data=16'h0000, ac_data_load=0, idle_cnt=0.
- Reset asserted mid-session aborts the session. Outputs reach reset values in the same edge.
- FSM states: IDLE, GRANT, SESSION, RELEASE.
- IDLE:
  - If term_req != 0, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo N_TERM. This is owner o.
  - Set term_grant = 1<<o and rr_ptr = o, then go to GRANT.
  - If term_req == 0, stay in IDLE.
- GRANT (1 cycle):
  - ac_request = term_request[o]; ac_data_load held 0; idle_cnt = 0.
  - Go to SESSION.
- SESSION:
  - Each cycle: ac_request <= term_request[o], ac_data <= term_data[o], ac_data_load <= term_load[o]. Latency is 1 cycle from terminal to AccessControl.
  - Requests and strobes from non-owners are ignored.
  - term_load[o]=1 clears idle_cnt; otherwise idle_cnt increments.
  - If term_req[o]=0, go to RELEASE. This exit has priority over timeout.
  - Else, if idle_cnt reaches TIMEOUT-1 with no load, pulse term_timeout[o] for 1 cycle and go to RELEASE.
- RELEASE (1 cycle):
  - ac_data_load=0, ac_request=2'b00, term_grant=0. ac_data keeps its last value.
  - Go to IDLE. Re-arbitration therefore happens no earlier than the following cycle.
  - A load strobe arriving in RELEASE is dropped.
- Status return: term_status slice o <= ac_status while term_grant[o]=1 (1-cycle registered). All other slices are 0. All slices are 0 in IDLE and RELEASE.
- Fairness:
  - The previous owner has lowest priority at the next arbitration.
  - A terminal that times out but keeps term_req high is re-queued normally and is not blacklisted.
- Simultaneous term_req and term_load from the owner in its final cycle: the load is forwarded; release follows on the next cycle.
- A timed-out owner must drop term_req before its timeout is cleared in its own logic; the arbiter does not wait for it.

Decomposition:
- Shared package ac_pkg holds:
  - the state encoding (IDLE=2'd0, GRANT=2'd1, SESSION=2'd2, RELEASE=2'd3);
  - request-code constants (REQ_NONE=2'b00, REQ_ACCESS=2'b01);
  - DATA_W=16 and STATUS_W=3.
- Sub-module rr_picker: combinational N_TERM-wide round-robin priority encoder. Inputs are req and ptr; outputs are valid and idx.
- Counter and FSM live in access_arbiter.

Test Plan (N_TERM=4, TIMEOUT=8):
- Reset: hold rst=1 for 2 cycles with term_req=4'b1111 -> all outputs 0; first grant after release of rst is term_grant=4'b0001 (ptr=3, wraps to 0).
- Forwarding: owner 0 with term_request=2'b01, term_data=16'h1476, term_load pulsed 1 cycle -> next cycle ac_data=16'h1476, ac_request=2'b01, ac_data_load=1 for exactly 1 cycle; ac_status=3'b101 appears on term_status[2:0] one cycle later, other slices 0.
- Isolation: terminal 2 pulses term_load with 16'hAAAA while terminal 0 owns the session -> ac_data_load stays 0 and ac_data is unchanged.
- Round-robin: term_req=4'b1011 held, each owner drops req after one load -> grant order 0,1,3,0; GRANT and RELEASE each take exactly 1 cycle between owners.
- Timeout: owner 1 holds term_req with no loads -> term_timeout[1] pulses 8 cycles after entering SESSION, term_grant is 0 the next cycle, then terminal 3 (also requesting) is granted.
- Reset mid-session: rst=1 during SESSION with ac_data_load=1 -> ac_data_load=0, term_grant=0 on the same edge; FSM back in IDLE.
